// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue in front of the register file: accepts results from
// SRC_NUM producers and drains up to WRITE_NUM oldest entries per cycle onto registered write ports.
module regfile_writeback_queue #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WRITE_NUM  = 4,
  parameter int SRC_NUM    = 4,
  parameter int DEPTH      = 8,
  localparam int AW = $clog2(REG_NUM),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic [SRC_NUM-1:0]              srcValid,
  output logic [SRC_NUM-1:0]              srcReady,
  input  logic [AW*SRC_NUM-1:0]           srcAddr,
  input  logic [DATA_WIDTH*SRC_NUM-1:0]   srcData,
  output logic [WRITE_NUM-1:0]            writeEnable,
  output logic [AW*WRITE_NUM-1:0]         writeAddr,
  output logic [DATA_WIDTH*WRITE_NUM-1:0] dataInputs,
  output logic [CW-1:0]                   count,
  output logic                            idle
);

  logic [AW-1:0]         mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         free, n_drain, enq_cnt;
  logic [SRC_NUM-1:0]    keep;
  logic [PW-1:0]         enq_slot [SRC_NUM];
  logic [WRITE_NUM-1:0]  drain_en;
  logic [AW-1:0]         rd_addr [WRITE_NUM];
  logic [DATA_WIDTH-1:0] rd_data [WRITE_NUM];

  assign free    = CW'(DEPTH) - count;
  assign n_drain = (count < CW'(WRITE_NUM)) ? count : CW'(WRITE_NUM);
  assign idle    = (count == '0) && (writeEnable == '0);

  // Ready is a pure function of occupancy, so producers never see a combinational path from valid.
  always_comb begin
    srcReady = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      srcReady[i] = free > CW'(i);
    end
  end

  // Kept transfers are packed at the tail in ascending source order; writes to register 0 are discarded.
  always_comb begin
    keep    = '0;
    enq_cnt = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      // NOTE: enq_cnt is a running sum inside one combinational pass, so blocking updates are intended here.
      enq_slot[i] = tail + enq_cnt[PW-1:0];
      if (srcValid[i] && srcReady[i] && (srcAddr[AW*i +: AW] != '0)) begin
        keep[i] = 1'b1;
        enq_cnt = enq_cnt + CW'(1);
      end
    end
  end

  // The youngest of several drained entries to one register wins; older ones pop silently.
  always_comb begin
    drain_en = '0;
    for (int j = 0; j < WRITE_NUM; j++) begin
      rd_addr[j] = mem_addr[head + PW'(j)];
      rd_data[j] = mem_data[head + PW'(j)];
    end
    for (int j = 0; j < WRITE_NUM; j++) begin
      drain_en[j] = CW'(j) < n_drain;
      for (int k = j + 1; k < WRITE_NUM; k++) begin
        if ((CW'(k) < n_drain) && (rd_addr[k] == rd_addr[j])) begin
          drain_en[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      writeEnable <= '0;
      writeAddr   <= '0;
      dataInputs  <= '0;
    end else begin
      head        <= head + PW'(n_drain);
      tail        <= tail + PW'(enq_cnt);
      count       <= count + enq_cnt - n_drain;
      writeEnable <= drain_en;
      for (int j = 0; j < WRITE_NUM; j++) begin
        if (CW'(j) < n_drain) begin
          writeAddr[AW*j +: AW]                 <= rd_addr[j];
          dataInputs[DATA_WIDTH*j +: DATA_WIDTH] <= rd_data[j];
        end
      end
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers and count already empties the queue.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SRC_NUM; i++) begin
      if (keep[i]) begin
        mem_addr[enq_slot[i]] <= srcAddr[AW*i +: AW];
        mem_data[enq_slot[i]] <= srcData[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: default config, a 2-write-port config
// and an 8-source config used to reach a full queue.
module tb_regfile_writeback_queue;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  // default configuration: W=4, S=4, D=8
  logic [3:0]   v1, r1, we1;
  logic [19:0]  a1, wa1;
  logic [127:0] d1, wd1;
  logic [3:0]   cnt1;
  logic         idle1;

  // W=2, S=4, D=8
  logic [3:0]   v2, r2;
  logic [1:0]   we2;
  logic [19:0]  a2;
  logic [9:0]   wa2;
  logic [127:0] d2;
  logic [63:0]  wd2;
  logic [3:0]   cnt2;
  logic         idle2;

  // W=2, S=8, D=8
  logic [7:0]   v3, r3;
  logic [1:0]   we3;
  logic [39:0]  a3;
  logic [9:0]   wa3;
  logic [255:0] d3;
  logic [63:0]  wd3;
  logic [3:0]   cnt3;
  logic         idle3;

  regfile_writeback_queue dut1 (
    .clk(clk), .rstN(rstN), .srcValid(v1), .srcReady(r1), .srcAddr(a1), .srcData(d1),
    .writeEnable(we1), .writeAddr(wa1), .dataInputs(wd1), .count(cnt1), .idle(idle1));

  regfile_writeback_queue #(.WRITE_NUM(2)) dut2 (
    .clk(clk), .rstN(rstN), .srcValid(v2), .srcReady(r2), .srcAddr(a2), .srcData(d2),
    .writeEnable(we2), .writeAddr(wa2), .dataInputs(wd2), .count(cnt2), .idle(idle2));

  regfile_writeback_queue #(.WRITE_NUM(2), .SRC_NUM(8)) dut3 (
    .clk(clk), .rstN(rstN), .srcValid(v3), .srcReady(r3), .srcAddr(a3), .srcData(d3),
    .writeEnable(we3), .writeAddr(wa3), .dataInputs(wd3), .count(cnt3), .idle(idle3));

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for dut2: every enabled write must match the oldest outstanding transfer.
  task automatic mon2();
    ent_t e;
    for (int j = 0; j < 2; j++) begin
      if (we2[j]) begin
        check("t4_write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          popped++;
          check("t4_addr", 64'(wa2[5*j +: 5]), 64'(e.a));
          check("t4_data", 64'(wd2[32*j +: 32]), 64'(e.d));
        end
      end
    end
  endtask

  task automatic drive2(input int c);
    for (int i = 0; i < 4; i++) begin
      a2[5*i +: 5]   = 5'(1 + ((4*c + i) % 31));
      d2[32*i +: 32] = 32'(c*16 + i);
    end
    v2 = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t e;
    logic [3:0] exp_r;
    rstN = 1'b0;
    v1 = '0; a1 = '0; d1 = '0;
    v2 = '0; a2 = '0; d2 = '0;
    v3 = '0; a3 = '0; d3 = '0;

    // reset state
    #3;
    check("rst_count", 64'(cnt1), 64'd0);
    check("rst_idle", 64'(idle1), 64'd1);
    check("rst_we", 64'(we1), 64'd0);
    check("rst_ready", 64'(r1), 64'hF);
    #9 rstN = 1'b1;
    tick();

    // 1: single write
    v1 = 4'b0001; a1[4:0] = 5'd5; d1[31:0] = 32'hA5;
    tick();
    check("t1_count1", 64'(cnt1), 64'd1);
    check("t1_we_early", 64'(we1), 64'd0);
    v1 = '0;
    tick();
    check("t1_we", 64'(we1), 64'b0001);
    check("t1_addr", 64'(wa1[4:0]), 64'd5);
    check("t1_data", 64'(wd1[31:0]), 64'hA5);
    check("t1_count0", 64'(cnt1), 64'd0);
    check("t1_busy", 64'(idle1), 64'd0);
    tick();
    check("t1_we_off", 64'(we1), 64'd0);
    check("t1_idle", 64'(idle1), 64'd1);
    check("t1_hold", 64'(wa1[19:5]), 64'd0);

    // 2: address-0 transfer dropped
    v1 = 4'b0110; a1[9:5] = 5'd0; d1[63:32] = 32'hFF; a1[14:10] = 5'd3; d1[95:64] = 32'h33;
    check("t2_ready", 64'(r1), 64'hF);
    tick();
    check("t2_count", 64'(cnt1), 64'd1);
    v1 = '0;
    tick();
    check("t2_we", 64'(we1), 64'b0001);
    check("t2_addr", 64'(wa1[4:0]), 64'd3);
    check("t2_data", 64'(wd1[31:0]), 64'h33);
    check("t2_count0", 64'(cnt1), 64'd0);
    tick();
    check("t2_idle", 64'(idle1), 64'd1);

    // 3: same-address merge
    v1 = 4'b0011; a1[4:0] = 5'd7; d1[31:0] = 32'd1; a1[9:5] = 5'd7; d1[63:32] = 32'd2;
    tick();
    check("t3_count", 64'(cnt1), 64'd2);
    v1 = '0;
    tick();
    check("t3_we", 64'(we1), 64'b0010);
    check("t3_addr", 64'(wa1[9:5]), 64'd7);
    check("t3_data", 64'(wd1[63:32]), 64'd2);
    tick();
    check("t3_we_off", 64'(we1), 64'd0);

    // 5: 40 single writes, order kept across pointer wrap
    for (int t = 0; t <= 40; t++) begin
      if (t < 40) begin
        v1 = 4'b0001; a1[4:0] = 5'((t % 31) + 1); d1[31:0] = 32'(t);
      end else begin
        v1 = '0;
      end
      tick();
      check("t5_count", 64'(cnt1), (t < 40) ? 64'd1 : 64'd0);
      if (t >= 1) begin
        check("t5_we", 64'(we1), 64'b0001);
        check("t5_addr", 64'(wa1[4:0]), 64'(((t - 1) % 31) + 1));
        check("t5_data", 64'(wd1[31:0]), 64'(t - 1));
      end
    end
    tick();
    check("t5_we_off", 64'(we1), 64'd0);
    check("t5_idle", 64'(idle1), 64'd1);
    check("unused_addr_hold", 64'(wa1[19:10]), 64'd0);
    check("unused_data_hold", wd1[127:64], 64'd0);

    // 4: W=2, all sources valid every cycle
    for (int c = 0; c < 4; c++) begin
      drive2(c);
      exp_r = (c < 2) ? 4'hF : 4'h3;
      check("t4_ready", 64'(r2), 64'(exp_r));
      for (int i = 0; i < 4; i++) begin
        if (exp_r[i]) begin
          e.a = 5'(1 + ((4*c + i) % 31));
          e.d = 32'(c*16 + i);
          exp_q.push_back(e);
          pushed++;
        end
      end
      tick();
      mon2();
      check("t4_count", 64'(cnt2), (c == 0) ? 64'd4 : 64'd6);
    end
    v2 = '0;
    for (int t = 0; t < 4; t++) begin
      tick();
      mon2();
    end
    check("t4_drained", 64'(cnt2), 64'd0);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);
    check("t4_pushed", 64'(pushed), 64'd12);
    check("t4_popped", 64'(popped), 64'd12);

    // full queue: 8 sources fill all 8 entries in one edge
    for (int i = 0; i < 8; i++) begin
      a3[5*i +: 5]   = 5'(i + 1);
      d3[32*i +: 32] = 32'(48 + i);
    end
    v3 = 8'hFF;
    check("full_ready_empty", 64'(r3), 64'hFF);
    tick();
    check("full_count8", 64'(cnt3), 64'd8);
    check("full_ready0", 64'(r3), 64'h00);
    check("full_we0", 64'(we3), 64'd0);
    tick();
    check("full_count6", 64'(cnt3), 64'd6);
    check("full_ready6", 64'(r3), 64'h03);
    check("full_we", 64'(we3), 64'b11);
    check("full_addr0", 64'(wa3[4:0]), 64'd1);
    check("full_addr1", 64'(wa3[9:5]), 64'd2);
    check("full_data0", 64'(wd3[31:0]), 64'd48);
    check("full_data1", 64'(wd3[63:32]), 64'd49);
    v3 = '0;
    for (int t = 0; t < 3; t++) tick();
    check("full_drained", 64'(cnt3), 64'd0);
    tick();
    check("full_idle", 64'(idle3), 64'd1);

    // 6: sub-cycle reset pulse at count 6
    drive2(0);
    tick();
    drive2(1);
    tick();
    check("t6_count6", 64'(cnt2), 64'd6);
    check("t6_we_busy", 64'(we2), 64'b11);
    v2 = '0;
    #2 rstN = 1'b0;
    #1;
    check("t6_we_rst", 64'(we2), 64'd0);
    check("t6_count_rst", 64'(cnt2), 64'd0);
    check("t6_idle_rst", 64'(idle2), 64'd1);
    #1 rstN = 1'b1;
    tick();
    check("t6_count_after", 64'(cnt2), 64'd0);
    check("t6_we_after", 64'(we2), 64'd0);
    check("t6_idle_after", 64'(idle2), 64'd1);
    v2 = 4'b0001; a2[4:0] = 5'd9; d2[31:0] = 32'h99;
    tick();
    check("t6_count1", 64'(cnt2), 64'd1);
    v2 = '0;
    tick();
    check("t6_we", 64'(we2), 64'b01);
    check("t6_addr", 64'(wa2[4:0]), 64'd9);
    check("t6_data", 64'(wd2[31:0]), 64'h99);
    tick();
    check("t6_idle", 64'(idle2), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
